multicycle_main_control: RTL
============================

Name: multicycle_main_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps from the 6-bit opcode.
- Drives every datapath enable/mux select and the 2-bit alu_op consumed by the ALU control decoder (00 add, 01 sub, 10 decode funct).
- Also provides an instruction-retire pulse and a retire counter for debug/performance.

Parameters:
CNT_W, 32, width of retired_count (wraps modulo 2^CNT_W)

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instruction[31:26] from IR; stable from DECODE until instruction retires
mem_ready  in  1  memory handshake; used only with MEM_WAIT_EN, ignored otherwise
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
i_or_d  out  1  memory address select: 0 PC, 1 ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
mem_to_reg  out  1  writeback select: 0 ALUOut, 1 MDR
reg_dst  out  1  dest select: 0 rt, 1 rd
reg_write  out  1  register file write
alu_src_a  out  1  0 PC, 1 A
alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op  out  2  to ALU control: 00 add, 01 sub, 10 funct
pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
state  out  4  current state encoding (debug)
instr_retired  out  1  one-cycle pulse in final state of each legal instruction
illegal_op  out  1  one-cycle pulse on unsupported opcode
retired_count  out  CNT_W  count of retired instructions

Behaviour:
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000; all others illegal.
- States: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, R_EXEC 7, R_WB 8, BRANCH 9, JUMP 10, ADDI_EXEC 11, ADDI_WB 12, TRAP 13. Codes 14–15 are unreachable; if entered, go to FETCH.
- Reset (async, rst_n=0): state=IDLE, retired_count=0; all outputs 0.
- First rising edge after release: IDLE→FETCH. IDLE is never re-entered except by reset.
- Outputs are Moore-decoded from state only. Outputs not listed for a state are 0.
  - FETCH: mem_read=1, ir_write=1, pc_write=1, alu_src_b=01, alu_op=00.
  - DECODE: alu_src_b=11, alu_op=00.
  - MEM_ADDR, ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEM_READ: mem_read=1, i_or_d=1.
  - MEM_WB: reg_write=1, mem_to_reg=1.
  - MEM_WRITE: mem_write=1, i_or_d=1.
  - R_EXEC: alu_src_a=1, alu_op=10.
  - R_WB: reg_write=1, reg_dst=1.
  - BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01.
  - JUMP: pc_write=1, pc_source=10.
  - ADDI_WB: reg_write=1.
  - TRAP: illegal_op=1, no writes.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEM_ADDR (LW/SW), R_EXEC, BRANCH, JUMP, ADDI_EXEC, or TRAP (illegal).
  - MEM_ADDR→MEM_READ (LW) / MEM_WRITE (SW); opcode is re-sampled here.
  - MEM_READ→MEM_WB; R_EXEC→R_WB; ADDI_EXEC→ADDI_WB.
  - MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB, TRAP→FETCH.
- Latency in cycles including FETCH: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3, illegal 3.
- instr_retired=1 in MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB (not TRAP). retired_count increments by 1 on the same clock edge and wraps from all-ones to 0.
- Reset mid-instruction: immediate return to IDLE; no partial retire is counted.

Optional Feature:
MEM_WAIT_EN
- Defined: FETCH, MEM_READ and MEM_WRITE hold while mem_ready=0.
  - mem_read/mem_write and i_or_d stay asserted while holding.
  - In FETCH, ir_write and pc_write assert only in the cycle where mem_ready=1.
  - In MEM_WRITE, instr_retired pulses and the counter increments only when mem_ready=1.
  - Exit on the edge where mem_ready=1.
- Undefined: mem_ready is ignored; every state lasts exactly one cycle.

Test Plan:
- Reset held, then released; opcode=100011 → state 0, all outputs 0; then state sequence 1,2,3,4,5,1; reg_write=1 and mem_to_reg=1 only in state 5; retired_count=1.
- R-type (000000) → states 1,2,7,8; alu_op=10 in state 7; reg_dst=1 and reg_write=1 in state 8; instr_retired pulses once.
- BEQ (000100) then J (000010) → BEQ: state 9 with alu_op=01, pc_write_cond=1, pc_source=01. J: state 10 with pc_write=1, pc_source=10. Each takes 3 cycles; retired_count +2.
- Opcode 111111 → states 1,2,13,1; illegal_op pulses once; no reg_write/mem_write; retired_count unchanged.
- rst_n asserted low during MEM_READ → state=0 asynchronously; retired_count=0.
- CNT_W=4, with counter preloaded to 15 by executing 15 ADDI (001000) instructions, then one more ADDI → retired_count wraps to 0.
- With MEM_WAIT_EN, mem_ready=0 for 3 cycles in FETCH → FETCH lasts 4 cycles; ir_write and pc_write high only in the 4th cycle.

Source files
------------

// File: rtl/multicycle_main_control_if.sv
// multicycle_main_control_if: opcode/handshake inputs and datapath control outputs of the main control FSM
interface multicycle_main_control_if #(parameter int CNT_W = 32);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic [3:0]       state;
  logic             instr_retired;
  logic             illegal_op;
  logic [CNT_W-1:0] retired_count;
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state,
           instr_retired, illegal_op, retired_count
  );
  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state,
           instr_retired, illegal_op, retired_count
  );
endinterface

// File: rtl/multicycle_main_control.sv
// multicycle_main_control: Moore main control FSM for the multi-cycle MIPS datapath with retire counter.
// Define MEM_WAIT_EN to make FETCH/MEM_READ/MEM_WRITE hold until mem_ready.
module multicycle_main_control #(
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  multicycle_main_control_if.master  bus
);
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    ADDI_EXEC = 4'd11,
    ADDI_WB   = 4'd12,
    TRAP      = 4'd13
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy;
  logic             retire;
  logic [5:0]       op;
`ifdef MEM_WAIT_EN
  assign rdy = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign rdy = 1'b1;
`endif
  assign op = bus.opcode;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d           = state_q;
    retire            = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 2'b00;
    bus.illegal_op    = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.ir_write  = rdy;
        bus.pc_write  = rdy;
        bus.alu_src_b = 2'b01;
        state_d       = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        state_d = (op == OP_LW || op == OP_SW) ? MEM_ADDR :
                  (op == OP_R)                 ? R_EXEC   :
                  (op == OP_BEQ)               ? BRANCH   :
                  (op == OP_J)                 ? JUMP     :
                  (op == OP_ADDI)              ? ADDI_EXEC : TRAP;
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = (op == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        state_d      = rdy ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        retire         = 1'b1;
        state_d        = FETCH;
      end
      MEM_WRITE: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        retire        = rdy;
        state_d       = rdy ? FETCH : MEM_WRITE;
      end
      R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        state_d       = R_WB;
      end
      R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        retire        = 1'b1;
        state_d       = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        retire            = 1'b1;
        state_d           = FETCH;
      end
      JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        retire        = 1'b1;
        state_d       = FETCH;
      end
      ADDI_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = ADDI_WB;
      end
      ADDI_WB: begin
        bus.reg_write = 1'b1;
        retire        = 1'b1;
        state_d       = FETCH;
      end
      TRAP: begin
        bus.illegal_op = 1'b1;
        state_d        = FETCH;
      end
      default: state_d = FETCH;
    endcase
    cnt_d = cnt_q + CNT_W'(retire);
  end
  assign bus.state         = state_q;
  assign bus.instr_retired = retire;
  assign bus.retired_count = cnt_q;
endmodule
